// File: rtl/conv_pkg.sv
// ---------------------------------------------------------------------------
// conv_pkg
// Shared definitions for the 1-D convolution sequencer.
//   conv_state_t : sequencer FSM states
//   CONV_DW      : default width of the index/size fields
//   conv_len_f   : output length N+M-1 of a linear convolution
// ---------------------------------------------------------------------------
package conv_pkg;

    localparam int CONV_DW = 5;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        INIT  = 3'd1,
        MAC   = 3'd2,
        DRAIN = 3'd3,
        WRITE = 3'd4,
        DONE  = 3'd5
    } conv_state_t;

    // Number of output samples of x (length n) convolved with h (length m).
    // Callers guarantee n and m are both non-zero.
    function automatic int unsigned conv_len_f(input int unsigned n,
                                               input int unsigned m);
        return n + m - 1;
    endfunction

endpackage

// File: rtl/conv_bounds.sv
// ---------------------------------------------------------------------------
// conv_bounds
// Combinational overlap window of output sample i for x of length n and h of
// length m: j runs from j_lo to j_hi inclusive.
//   i    in  DATA_WIDTH+1  outer index
//   n    in  DATA_WIDTH    length of x (non-zero while in use)
//   m    in  DATA_WIDTH    length of h (non-zero while in use)
//   j_lo out DATA_WIDTH    first inner index, (i >= m) ? i-m+1 : 0
//   j_hi out DATA_WIDTH    last inner index,  (i < n)  ? i     : n-1
// ---------------------------------------------------------------------------
module conv_bounds
    import conv_pkg::*;
#(
    parameter int DATA_WIDTH = CONV_DW
) (
    input  logic [DATA_WIDTH:0]   i,
    input  logic [DATA_WIDTH-1:0] n,
    input  logic [DATA_WIDTH-1:0] m,
    output logic [DATA_WIDTH-1:0] j_lo,
    output logic [DATA_WIDTH-1:0] j_hi
);

    localparam logic [DATA_WIDTH-1:0] ONE_DW = DATA_WIDTH'(1);

    logic [DATA_WIDTH:0] n_ext;
    logic [DATA_WIDTH:0] m_ext;

    assign n_ext = {1'b0, n};
    assign m_ext = {1'b0, m};

    // Both results are below n, so the low DATA_WIDTH bits of i are enough:
    // modular subtraction on the truncated value yields the exact result.
    assign j_lo = (i >= m_ext) ? (i[DATA_WIDTH-1:0] - m + ONE_DW) : '0;
    assign j_hi = (i <  n_ext) ? i[DATA_WIDTH-1:0] : (n - ONE_DW);

endmodule

// File: rtl/convolution_seq.sv
// ---------------------------------------------------------------------------
// convolution_seq
// Address/strobe sequencer for y[i] = sum_j x[j]*h[i-j].
// For every output sample: INIT (clear accumulator), one MAC cycle per j in
// the overlap window, DRAIN (last product accumulates), WRITE (store y[i]).
//   clk        in   system clock
//   rstn       in   asynchronous active-low reset
//   start_i    in   start request, honoured only in IDLE
//   sizex_i    in   length N of x, latched on accepted start
//   sizeh_i    in   length M of h, latched on accepted start
//   busy_o     out  run in progress (INIT..DONE)
//   done_o     out  one-cycle completion pulse
//   rd_en_o    out  X/H read strobe
//   addr_x_o   out  x address (j), held outside MAC
//   addr_h_o   out  h address (i-j), held outside MAC
//   j_o        out  current inner index
//   acc_clr_o  out  accumulator clear
//   mac_en_o   out  accumulate enable (rd_en_o delayed one cycle)
//   y_we_o     out  Y write strobe
//   addr_y_o   out  y address (i), meaningful while y_we_o is high
// ---------------------------------------------------------------------------
module convolution_seq
    import conv_pkg::*;
#(
    parameter int DATA_WIDTH = CONV_DW
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  start_i,
    input  logic [DATA_WIDTH-1:0] sizex_i,
    input  logic [DATA_WIDTH-1:0] sizeh_i,
    output logic                  busy_o,
    output logic                  done_o,
    output logic                  rd_en_o,
    output logic [DATA_WIDTH-1:0] addr_x_o,
    output logic [DATA_WIDTH-1:0] addr_h_o,
    output logic [DATA_WIDTH-1:0] j_o,
    output logic                  acc_clr_o,
    output logic                  mac_en_o,
    output logic                  y_we_o,
    output logic [DATA_WIDTH:0]   addr_y_o
);

    localparam logic [DATA_WIDTH-1:0] ONE_DW = DATA_WIDTH'(1);
    localparam logic [DATA_WIDTH:0]   ONE_I  = (DATA_WIDTH+1)'(1);

    conv_state_t state_reg, state_next;

    logic [DATA_WIDTH:0]   i_reg, i_next;
    logic [DATA_WIDTH-1:0] j_reg, j_next;
    logic [DATA_WIDTH-1:0] h_reg, h_next;   // tracks i-j alongside j
    logic [DATA_WIDTH-1:0] n_reg, n_next;
    logic [DATA_WIDTH-1:0] m_reg, m_next;
    logic                  mac_en_reg;

    logic [DATA_WIDTH-1:0] j_lo;
    logic [DATA_WIDTH-1:0] j_hi;
    logic                  sizes_zero;
    logic                  last_i;
    logic                  last_j;

    conv_bounds #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_bounds (
        .i    (i_reg),
        .n    (n_reg),
        .m    (m_reg),
        .j_lo (j_lo),
        .j_hi (j_hi)
    );

    assign sizes_zero = (sizex_i == '0) || (sizeh_i == '0);
    assign last_j     = (j_reg == j_hi);
    // Last output index is N+M-2; only evaluated in WRITE, where N,M >= 1.
    assign last_i     = (i_reg == (DATA_WIDTH+1)'(conv_len_f(32'(n_reg), 32'(m_reg)) - 32'd1));

    // ---------------- state register ----------------
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // ---------------- next-state logic ----------------
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (start_i) state_next = sizes_zero ? DONE : INIT;
            INIT:    state_next = MAC;
            MAC:     if (last_j) state_next = DRAIN;
            DRAIN:   state_next = WRITE;
            WRITE:   state_next = last_i ? DONE : INIT;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // ---------------- output logic ----------------
    always_comb begin
        busy_o    = 1'b0;
        done_o    = 1'b0;
        rd_en_o   = 1'b0;
        acc_clr_o = 1'b0;
        y_we_o    = 1'b0;
        case (state_reg)
            INIT:  begin busy_o = 1'b1; acc_clr_o = 1'b1; end
            MAC:   begin busy_o = 1'b1; rd_en_o   = 1'b1; end
            DRAIN: begin busy_o = 1'b1; end
            WRITE: begin busy_o = 1'b1; y_we_o    = 1'b1; end
            DONE:  begin busy_o = 1'b1; done_o    = 1'b1; end
            default: ;
        endcase
    end

    // ---------------- index datapath ----------------
    // j and i-j are loaded on the INIT->MAC edge and only step inside MAC, so
    // the read addresses naturally hold their last values in other states.
    always_comb begin
        i_next = i_reg;
        j_next = j_reg;
        h_next = h_reg;
        n_next = n_reg;
        m_next = m_reg;
        case (state_reg)
            IDLE: begin
                if (start_i) begin
                    n_next = sizex_i;
                    m_next = sizeh_i;
                    i_next = '0;
                end
            end
            INIT: begin
                j_next = j_lo;
                h_next = i_reg[DATA_WIDTH-1:0] - j_lo;
            end
            MAC: begin
                if (!last_j) begin
                    j_next = j_reg + ONE_DW;
                    h_next = h_reg - ONE_DW;
                end
            end
            WRITE: begin
                if (!last_i) i_next = i_reg + ONE_I;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            i_reg      <= '0;
            j_reg      <= '0;
            h_reg      <= '0;
            n_reg      <= '0;
            m_reg      <= '0;
            mac_en_reg <= 1'b0;
        end else begin
            i_reg      <= i_next;
            j_reg      <= j_next;
            h_reg      <= h_next;
            n_reg      <= n_next;
            m_reg      <= m_next;
            // Memory data arrives one cycle after the read strobe.
            mac_en_reg <= rd_en_o;
        end
    end

    assign addr_x_o = j_reg;
    assign j_o      = j_reg;
    assign addr_h_o = h_reg;
    assign addr_y_o = i_reg;
    assign mac_en_o = mac_en_reg;

endmodule

// File: tb/tb_convolution_seq.sv
// ---------------------------------------------------------------------------
// tb_convolution_seq
// Cycle-accurate trace scoreboard for convolution_seq. Each run builds the
// expected per-cycle output trace and the expected Y write addresses from the
// convolution definition, then drives start and pops/compares every cycle.
// ---------------------------------------------------------------------------
module tb_convolution_seq;

    localparam int DW = 5;

    logic          clk = 1'b0;
    logic          rstn = 1'b0;
    logic          start_i = 1'b0;
    logic [DW-1:0] sizex_i = '0;
    logic [DW-1:0] sizeh_i = '0;
    logic          busy_o, done_o, rd_en_o, acc_clr_o, mac_en_o, y_we_o;
    logic [DW-1:0] addr_x_o, addr_h_o, j_o;
    logic [DW:0]   addr_y_o;

    always #5 clk = ~clk;

    convolution_seq #(.DATA_WIDTH(DW)) dut (
        .clk       (clk),
        .rstn      (rstn),
        .start_i   (start_i),
        .sizex_i   (sizex_i),
        .sizeh_i   (sizeh_i),
        .busy_o    (busy_o),
        .done_o    (done_o),
        .rd_en_o   (rd_en_o),
        .addr_x_o  (addr_x_o),
        .addr_h_o  (addr_h_o),
        .j_o       (j_o),
        .acc_clr_o (acc_clr_o),
        .mac_en_o  (mac_en_o),
        .y_we_o    (y_we_o),
        .addr_y_o  (addr_y_o)
    );

    typedef struct packed {
        logic          busy;
        logic          done;
        logic          rd_en;
        logic          acc_clr;
        logic          mac_en;
        logic          y_we;
        logic [DW-1:0] ax;
        logic [DW-1:0] ah;
        logic [DW-1:0] jo;
        logic [DW:0]   ay;
    } obs_t;

    typedef struct {
        obs_t o;
        int   i;
    } step_t;

    step_t         exp_q[$];
    int            y_q[$];
    int            n_cmp = 0;
    int            n_bad = 0;
    logic [DW-1:0] last_x = '0;
    logic [DW-1:0] last_h = '0;

    // Observed outputs; addr_y only carries meaning during a write.
    function automatic obs_t sample();
        obs_t s;
        s.busy    = busy_o;
        s.done    = done_o;
        s.rd_en   = rd_en_o;
        s.acc_clr = acc_clr_o;
        s.mac_en  = mac_en_o;
        s.y_we    = y_we_o;
        s.ax      = addr_x_o;
        s.ah      = addr_h_o;
        s.jo      = j_o;
        s.ay      = y_we_o ? addr_y_o : '0;
        return s;
    endfunction

    // Quiet outputs with the read addresses holding their last MAC values.
    function automatic obs_t idle_obs();
        obs_t s;
        s         = '0;
        s.ax      = last_x;
        s.jo      = last_x;
        s.ah      = last_h;
        return s;
    endfunction

    task automatic push_step(input obs_t o, input int i);
        step_t st;
        st.o = o;
        st.i = i;
        exp_q.push_back(st);
    endtask

    // Reference model: expected output trace from the cycle after start.
    task automatic build_trace(input int n, input int m);
        obs_t s;
        int   lo, hi;
        if (n != 0 && m != 0) begin
            for (int i = 0; i <= n + m - 2; i++) begin
                lo = (i >= m) ? i - m + 1 : 0;
                hi = (i < n) ? i : n - 1;
                s = idle_obs(); s.busy = 1'b1; s.acc_clr = 1'b1;
                push_step(s, i);
                for (int j = lo; j <= hi; j++) begin
                    last_x = DW'(j);
                    last_h = DW'(i - j);
                    s = idle_obs(); s.busy = 1'b1; s.rd_en = 1'b1;
                    s.mac_en = (j != lo);
                    push_step(s, i);
                end
                s = idle_obs(); s.busy = 1'b1; s.mac_en = 1'b1;
                push_step(s, i);
                s = idle_obs(); s.busy = 1'b1; s.y_we = 1'b1; s.ay = (DW+1)'(i);
                push_step(s, i);
                y_q.push_back(i);
            end
        end
        s = idle_obs(); s.busy = 1'b1; s.done = 1'b1;
        push_step(s, -1);
        s = idle_obs();
        push_step(s, -1);
    endtask

    // Drive a one-cycle start; returns just after the edge that samples it.
    task automatic start_run(input int n, input int m);
        @(posedge clk);
        #1;
        start_i = 1'b1;
        sizex_i = DW'(n);
        sizeh_i = DW'(m);
        @(posedge clk);
        #1;
        start_i = 1'b0;
    endtask

    task automatic test_reset();
        obs_t o, z;
        rstn = 1'b0;
        last_x = '0;
        last_h = '0;
        z = idle_obs();
        #2;
        o = sample();
        n_cmp++;
        if (o !== z) begin
            n_bad++;
            $display("FAIL reset_async: got %h required %h", o, z);
        end
        start_i = 1'b1;
        sizex_i = 5'd3;
        sizeh_i = 5'd2;
        repeat (2) @(posedge clk);
        @(negedge clk);
        o = sample();
        n_cmp++;
        if (o !== z) begin
            n_bad++;
            $display("FAIL reset_held: got %h required %h", o, z);
        end
        start_i = 1'b0;
        rstn = 1'b1;
        @(negedge clk);
        o = sample();
        n_cmp++;
        if (o !== z) begin
            n_bad++;
            $display("FAIL reset_idle: got %h required %h", o, z);
        end
        $display("reset: outputs checked");
    endtask

    task automatic test_runs();
        int    tn[5]    = '{3, 1, 0, 31, 4};
        int    tm[5]    = '{2, 1, 5, 31, 3};
        int    tdone[5] = '{19, 5, 1, 1145, 31};
        int    twr[5]   = '{4, 1, 0, 61, 6};
        step_t st;
        obs_t  o;
        int    cyc, wr, done_at, ey;
        for (int k = 0; k < 5; k++) begin
            build_trace(tn[k], tm[k]);
            start_run(tn[k], tm[k]);
            cyc = 0; wr = 0; done_at = -1;
            while (exp_q.size() > 0) begin
                @(negedge clk);
                cyc++;
                st = exp_q.pop_front();
                o = sample();
                n_cmp++;
                if (o !== st.o) begin
                    n_bad++;
                    $display("FAIL trace_%0dx%0d cycle %0d: got %h required %h",
                             tn[k], tm[k], cyc, o, st.o);
                end
                if (o.done && done_at < 0) done_at = cyc;
                if (o.y_we) begin
                    wr++;
                    n_cmp++;
                    if (y_q.size() == 0) begin
                        n_bad++;
                        $display("FAIL ywrite_%0dx%0d: got write to %0d required none",
                                 tn[k], tm[k], o.ay);
                    end else begin
                        ey = y_q.pop_front();
                        if (o.ay !== (DW+1)'(ey)) begin
                            n_bad++;
                            $display("FAIL yaddr_%0dx%0d: got %0d required %0d",
                                     tn[k], tm[k], o.ay, ey);
                        end
                        $display("run %0dx%0d: write y[%0d]", tn[k], tm[k], o.ay);
                    end
                end
            end
            n_cmp++;
            if (done_at != tdone[k]) begin
                n_bad++;
                $display("FAIL done_cycle_%0dx%0d: got %0d required %0d",
                         tn[k], tm[k], done_at, tdone[k]);
            end
            n_cmp++;
            if (wr != twr[k] || y_q.size() != 0) begin
                n_bad++;
                $display("FAIL write_count_%0dx%0d: got %0d required %0d (unwritten %0d)",
                         tn[k], tm[k], wr, twr[k], y_q.size());
            end
            y_q.delete();
            $display("run %0dx%0d: done at cycle %0d", tn[k], tm[k], done_at);
        end
    endtask

    task automatic test_reset_abort();
        step_t st;
        obs_t  o, z;
        int    cyc, wr;
        logic  aborted;
        build_trace(4, 3);
        start_run(4, 3);
        cyc = 0; wr = 0; aborted = 1'b0;
        while (exp_q.size() > 0 && !aborted) begin
            @(negedge clk);
            cyc++;
            st = exp_q.pop_front();
            o = sample();
            n_cmp++;
            if (o !== st.o) begin
                n_bad++;
                $display("FAIL abort_trace cycle %0d: got %h required %h", cyc, o, st.o);
            end
            if (o.y_we) wr++;
            if (st.i == 2 && st.o.rd_en) begin
                #1 rstn = 1'b0;
                #1;
                last_x = '0;
                last_h = '0;
                z = idle_obs();
                o = sample();
                n_cmp++;
                if (o !== z) begin
                    n_bad++;
                    $display("FAIL abort_same_cycle: got %h required %h", o, z);
                end
                aborted = 1'b1;
            end
        end
        exp_q.delete();
        y_q.delete();
        n_cmp++;
        if (!aborted || wr != 2) begin
            n_bad++;
            $display("FAIL abort_point: got aborted=%0d writes=%0d required aborted=1 writes=2",
                     aborted, wr);
        end
        @(posedge clk);
        @(negedge clk);
        o = sample();
        n_cmp++;
        if (o !== z) begin
            n_bad++;
            $display("FAIL abort_held: got %h required %h", o, z);
        end
        rstn = 1'b1;
        $display("abort 4x3: reset at cycle %0d after %0d writes", cyc, wr);
    endtask

    // 4x3 run right after the abort, with a second start pulsed during MAC.
    task automatic test_start_ignored();
        step_t st;
        obs_t  o;
        int    cyc, wr, done_at, ey;
        logic  poked;
        build_trace(4, 3);
        start_run(4, 3);
        cyc = 0; wr = 0; done_at = -1; poked = 1'b0;
        while (exp_q.size() > 0) begin
            @(negedge clk);
            cyc++;
            st = exp_q.pop_front();
            o = sample();
            n_cmp++;
            if (o !== st.o) begin
                n_bad++;
                $display("FAIL restart_trace cycle %0d: got %h required %h", cyc, o, st.o);
            end
            if (o.done && done_at < 0) done_at = cyc;
            if (o.y_we) begin
                wr++;
                n_cmp++;
                ey = (y_q.size() > 0) ? y_q.pop_front() : -1;
                if (o.ay !== (DW+1)'(ey) || ey < 0) begin
                    n_bad++;
                    $display("FAIL restart_yaddr: got %0d required %0d", o.ay, ey);
                end
                $display("restart 4x3: write y[%0d]", o.ay);
            end
            if (poked && start_i) begin
                start_i = 1'b0;
                sizex_i = 5'd4;
                sizeh_i = 5'd3;
            end else if (!poked && st.i == 1 && st.o.rd_en) begin
                start_i = 1'b1;
                sizex_i = 5'd7;
                sizeh_i = 5'd2;
                poked = 1'b1;
            end
        end
        n_cmp++;
        if (done_at != 31 || wr != 6 || y_q.size() != 0) begin
            n_bad++;
            $display("FAIL restart_summary: got done=%0d writes=%0d required done=31 writes=6",
                     done_at, wr);
        end
        y_q.delete();
    endtask

    initial begin
        test_reset();
        test_runs();
        test_reset_abort();
        test_start_ignored();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/convolution_seq.md
# convolution_seq

Sequencer for the 1-D linear convolution engine, y[i] = Σ x[j]·h[i−j]. Sits directly upstream of the inner-index accumulator and the MAC datapath. Runs the outer index i over every output sample and the inner index j over the valid overlap window. Drives the X/H sample-memory read addresses, the accumulator clear/enable strobes and the Y write strobe, with a start/busy/done handshake toward the host.

## Interface
- `DATA_WIDTH`, default 5: width of the x/h index and size fields (max length 2^DATA_WIDTH − 1).
- `clk`  in  1  system clock, all logic on the rising edge.
- `rstn`  in  1  asynchronous active-low reset.
- `start_i`  in  1  one-cycle request to begin a convolution; sampled only in IDLE.
- `sizex_i`  in  DATA_WIDTH  length N of x, latched on accepted start.
- `sizeh_i`  in  DATA_WIDTH  length M of h, latched on accepted start.
- `busy_o`  out  1  high from the cycle after accepted start until DONE inclusive.
- `done_o`  out  1  one-cycle pulse in DONE.
- `rd_en_o`  out  1  X/H memory read strobe (MAC state).
- `addr_x_o`  out  DATA_WIDTH  x address = j.
- `addr_h_o`  out  DATA_WIDTH  h address = i − j.
- `j_o`  out  DATA_WIDTH  current inner index (feeds inner-index stage).
- `acc_clr_o`  out  1  accumulator clear, one cycle per output sample.
- `mac_en_o`  out  1  accumulate enable, rd_en_o delayed 1 cycle.
- `y_we_o`  out  1  Y memory write strobe.
- `addr_y_o`  out  DATA_WIDTH+1  Y address = i.

## Operation
- States: IDLE, INIT, MAC, DRAIN, WRITE, DONE.
- IDLE: start_i=1 latches N and M. If N=0 or M=0, go to DONE with no reads or writes. Otherwise set i=0 and go to INIT.
- INIT: compute j_lo = (i ≥ M) ? i−M+1 : 0 and j_hi = (i < N) ? i : N−1. Set j=j_lo. Pulse acc_clr_o. Go to MAC.
- MAC: one cycle per j. rd_en_o=1, addr_x_o=j, addr_h_o=i−j. If j==j_hi go to DRAIN, else j←j+1.
- DRAIN: no read. mac_en_o is high for the last product.
- WRITE: y_we_o=1, addr_y_o=i. If i == N+M−2 go to DONE; else i←i+1 and go to INIT.
- DONE: done_o=1 for one cycle, then IDLE. busy_o drops together with the IDLE entry.
- Arithmetic:
  - i is DATA_WIDTH+1 bits, with maximum 2·(2^DATA_WIDTH−1)−2.
  - i−j is always within [0, M−1], so it is truncated to DATA_WIDTH bits without loss.
  - j_lo, j_hi and j are DATA_WIDTH bits.
- start_i while busy is ignored. Size inputs are not re-sampled during a run.

## Timing
- Reset: state=IDLE, i=j=0. Every output is 0, including busy_o, done_o, strobes and addresses.
- Reset asserted mid-run aborts immediately to the reset values. No partial write is issued after rstn falls.
- Memory read latency is fixed at 1 cycle. mac_en_o is rd_en_o registered once, so the product for address cycle t accumulates in cycle t+1.
- Cycles per output sample = L+3, where L = j_hi−j_lo+1 (INIT + L MAC + DRAIN + WRITE).
- Latency from start_i to first acc_clr_o is 1 cycle.
- Total run length: start cycle + Σ(L_i+3) + DONE.
- acc_clr_o and mac_en_o are never high in the same cycle. y_we_o never overlaps mac_en_o.
- Addresses are held at their last values outside MAC. addr_y_o is valid only when y_we_o=1.

## Structure
- Package `conv_pkg`:
  - `conv_state_t` enum (IDLE, INIT, MAC, DRAIN, WRITE, DONE).
  - `CONV_DW` default width constant.
  - `conv_len_f` helper computing N+M−1.
- One natural sub-module, `conv_bounds`: purely combinational, computes j_lo and j_hi from (i, N, M).
- The FSM, the i/j registers and the mac_en delay register live in convolution_seq.

## Test plan
- N=3, M=2, start pulse:
  - 4 writes at addr_y 0,1,2,3.
  - MAC (j, i−j) sequences: {(0,0)}, {(0,1),(1,0)}, {(1,1),(2,0)}, {(2,1)}.
  - done_o at cycle 19 after start; busy_o high for cycles 1–19.
- N=1, M=1: single MAC (0,0), y_we_o with addr_y_o=0, done_o 5 cycles after start.
- N=0, M=5: no rd_en_o/y_we_o ever; done_o 1 cycle after start; busy_o high 1 cycle.
- N=31, M=31 (max): 61 writes, addr_y_o ends at 60. i−j never exceeds 30. No address wrap.
- start_i re-pulsed during MAC of a N=4, M=3 run: ignored, output trace identical to an undisturbed run.
- rstn low during the MAC cycle of i=2 in an N=4, M=3 run: all outputs 0 in the same cycle. A later start_i produces a full clean run.
